spi_pwm_host: RTL and testbench
===============================

SPI_PWM_HOST -- requirements
Module: spi_pwm_host

Interface
REQ-001 SHALL have parameter HALF, default 4, meaning the number of clk cycles per SCLK half-period; the legal range is 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: a command is offered.
REQ-005 SHALL have port req_ready, output, 1 bit: the block is idle and accepts a command.
REQ-006 SHALL have port req_write, input, 1 bit: 1 means write, 0 means read.
REQ-007 SHALL have port req_addr, input, 1 bit: PWM channel address.
REQ-008 SHALL have port req_data, input, 8 bits: the write level; ignored on a read.
REQ-009 SHALL have port rsp_valid, output, 1 bit: a one-cycle pulse marking transaction complete.
REQ-010 SHALL have port rsp_data, output, 8 bits: the read result; 0x00 after a write.
REQ-011 SHALL have port sclk, output, 1 bit: SPI clock, idle low.
REQ-012 SHALL have port cs_n, output, 1 bit: chip select, active low, idle high.
REQ-013 SHALL have port mosi, output, 1 bit: host-to-responder data.
REQ-014 SHALL have port miso, input, 1 bit: responder-to-host data, asynchronous to clk.

Function
REQ-015 SHALL accept a command on a cycle where req_valid and req_ready are both 1, and SHALL latch req_write, req_addr and req_data on that cycle.
REQ-016 SHALL drive req_ready = 1 only in state IDLE.
REQ-017 SHALL form each transaction as 16 bits, MSB first on mosi: byte0 = {req_write, 6'b0, req_addr}, then byte1 = req_data on a write or 0x00 on a read.
REQ-018 SHALL implement the FSM IDLE -> SETUP -> (LOW -> HIGH) x16 -> TAIL -> DONE -> IDLE.
REQ-019 SHALL make every state except IDLE and DONE last exactly HALF cycles, and DONE last exactly 1 cycle.
REQ-020 SHALL drive cs_n low from the cycle after acceptance through the end of TAIL, and high in IDLE and DONE.
REQ-021 SHALL drive sclk = 1 only in HIGH.
REQ-022 SHALL drive mosi with the current bit for the whole of LOW and HIGH, and drive mosi = 0 in IDLE, SETUP, TAIL and DONE.
REQ-023 SHALL keep TAIL; its final falling SCLK edge is mandatory because the responder commits a write on it.
REQ-024 SHALL pass miso through a 2-flop synchronizer before any use.
REQ-025 SHALL, during bits 8..15, capture synchronized miso on the last cycle of each HIGH phase; bit 8 goes to rsp_data[0] and bit 15 to rsp_data[7] (LSB-first).
REQ-026 SHALL pulse rsp_valid for the single DONE cycle, holding rsp_data stable until the next rsp_valid; rsp_data = 0x00 on a write.
REQ-027 SHALL have a latency from the acceptance cycle to rsp_valid of 34*HALF+1 cycles (137 at HALF=4).
REQ-028 SHALL use a 4-bit bit counter (0..15) and an 8-bit phase counter, which wraps to 0 at the end of every phase.
REQ-029 SHALL ignore req_valid outside IDLE; there is no queuing and no abort.
REQ-030 SHALL leave cs_n high for at least 2 cycles (DONE plus IDLE) between back-to-back transactions, even when req_valid is held high.

Reset
REQ-031 SHALL, while reset is 1, force state IDLE, cs_n=1, sclk=0, mosi=0, rsp_valid=0, rsp_data=0x00, req_ready=0, all counters 0 and synchronizer flops 0.
REQ-032 SHALL, on reset mid-transaction, drop the transaction with no rsp_valid; cs_n rises at the next clk edge.
REQ-033 SHALL drive req_ready = 1 on the first cycle after reset deasserts.

Structure
REQ-034 SHALL place the FSM state enum, the command bit positions (WRITE_BIT=7, ADDR_BIT=0) and the transaction length of 16 in the shared package spi_pwm_pkg.
REQ-035 SHALL instantiate one sub-module, spi_half_timer: a HALF-cycle phase counter with a done strobe.
REQ-036 SHALL be self-contained otherwise, at an estimated 150-250 lines of RTL.

Verification
REQ-037 Bench SHALL pair the DUT with a behavioral SPI responder model that samples mosi on rising sclk, shifts miso LSB-first on falling sclk, and resets its state when cs_n is high.
REQ-038 Scenario: write addr 1, data 0xA5 -> responder level[1]=0xA5 after TAIL; mosi bits are 0x81 then 0xA5; rsp_valid at cycle 137; rsp_data=0x00.
REQ-039 Scenario: preload level[0]=0x3C, then read addr 0 -> mosi bits 0x00,0x00; rsp_data=0x3C.
REQ-040 Scenario: req_valid held high for 3 back-to-back commands -> exactly 3 rsp_valid pulses; cs_n high for at least 2 cycles between transactions; req_ready low throughout each transaction.
REQ-041 Scenario: reset asserted during bit 5 of a write of 0xFF -> cs_n=1 next cycle; no rsp_valid; responder level unchanged.
REQ-042 Scenario: HALF=2, write 0x01 then read it back -> readback 0x01; latency 69 cycles; SCLK high and low phases each exactly 2 cycles.
REQ-043 Scenario: toggle req_data during a transaction -> no effect; the transmitted data equals the value latched at acceptance.

Source files
------------

// File: rtl/spi_pwm_pkg.sv
// Shared definitions for the SPI PWM host: FSM states, command layout and frame length.
package spi_pwm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StHigh,
    StTail,
    StDone
  } state_e;

  // Bit positions inside the command byte (byte0).
  localparam int unsigned WRITE_BIT = 7;
  localparam int unsigned ADDR_BIT  = 0;

  // Bits per transaction and index of the last one.
  localparam int unsigned TXN_BITS = 16;
  localparam int unsigned LAST_BIT = TXN_BITS - 1;

  // Builds the 16-bit MOSI frame; the data byte is zero on a read.
  function automatic logic [TXN_BITS-1:0] build_frame(input logic       write,
                                                      input logic       addr,
                                                      input logic [7:0] data);
    logic [7:0] cmd;
    cmd            = 8'h00;
    cmd[WRITE_BIT] = write;
    cmd[ADDR_BIT]  = addr;
    return {cmd, (write ? data : 8'h00)};
  endfunction

endpackage

// File: rtl/spi_half_timer.sv
// Phase timer: counts HALF cycles while enabled and strobes done on the last one.
module spi_half_timer #(
  parameter int unsigned HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic done
);

  localparam logic [7:0] LastCnt = 8'(HALF - 1);

  logic [7:0] cnt_q, cnt_d;

  // Count up while enabled; wrap to 0 at the end of every phase or when disabled.
  always_comb begin
    done  = en && (cnt_q == LastCnt);
    cnt_d = cnt_q;
    if (!en || done) begin
      cnt_d = 8'h00;
    end else begin
      cnt_d = cnt_q + 8'h01;
    end
  end

  // Phase counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_pwm_host.sv
// SPI host for a two-channel PWM responder: one 16-bit read or write per command.
module spi_pwm_host
  import spi_pwm_pkg::*;
#(
  parameter int unsigned HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  state_e              state_q, state_d;
  logic [3:0]          bit_q, bit_d;
  logic [TXN_BITS-1:0] tx_q, tx_d;
  logic                write_q, write_d;
  logic [7:0]          rx_q, rx_d;
  logic [7:0]          rsp_data_q, rsp_data_d;
  logic                sync1_q, sync2_q;
  logic                timer_en;
  logic                phase_done;

  // Every state except IDLE and DONE is timed by the half-period counter.
  assign timer_en = (state_q != StIdle) && (state_q != StDone);

  spi_half_timer #(
    .HALF(HALF)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .en   (timer_en),
    .done (phase_done)
  );

  // Two-flop synchronizer for the asynchronous miso input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= miso;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: transaction sequencing, MOSI shifting and MISO capture.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    write_d    = write_q;
    rx_d       = rx_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StSetup;
          write_d = req_write;
          tx_d    = build_frame(req_write, req_addr, req_data);
          rx_d    = 8'h00;
          bit_d   = 4'd0;
        end
      end
      StSetup: begin
        if (phase_done) state_d = StLow;
      end
      StLow: begin
        if (phase_done) state_d = StHigh;
      end
      StHigh: begin
        if (phase_done) begin
          // Second byte carries the read data, LSB first.
          if (bit_q[3]) rx_d = {sync2_q, rx_q[7:1]};
          tx_d = {tx_q[TXN_BITS-2:0], 1'b0};
          if (bit_q == 4'(LAST_BIT)) begin
            state_d = StTail;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = StLow;
          end
        end
      end
      StTail: begin
        if (phase_done) begin
          state_d    = StDone;
          rsp_data_d = write_q ? 8'h00 : rx_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_q      <= 4'd0;
      tx_q       <= '0;
      write_q    <= 1'b0;
      rx_q       <= 8'h00;
      rsp_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      write_q    <= write_d;
      rx_q       <= rx_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Outputs decoded from state; handshake outputs are held off while reset is high.
  always_comb begin
    req_ready = (state_q == StIdle) && !reset;
    rsp_valid = (state_q == StDone) && !reset;
    cs_n      = !((state_q == StSetup) || (state_q == StLow) ||
                  (state_q == StHigh)  || (state_q == StTail));
    sclk      = (state_q == StHigh);
    mosi      = ((state_q == StLow) || (state_q == StHigh)) && tx_q[TXN_BITS-1];
    rsp_data  = rsp_data_q;
  end

endmodule

// File: tb/tb_spi_pwm_host.sv
// Bench for spi_pwm_host: two DUTs (HALF=4 and HALF=2) on a shared behavioral responder.
module tb_spi_pwm_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       sel;  // 0 selects the HALF=4 DUT, 1 the HALF=2 DUT
  logic       req_valid, req_write, req_addr;
  logic [7:0] req_data;
  logic       miso;

  logic       req_valid4, req_ready4, rsp_valid4, sclk4, cs_n4, mosi4;
  logic [7:0] rsp_data4;
  logic       req_valid2, req_ready2, rsp_valid2, sclk2, cs_n2, mosi2;
  logic [7:0] rsp_data2;

  logic       req_ready_m, rsp_valid_m, sclk_m, cs_n_m, mosi_m;
  logic [7:0] rsp_data_m;

  assign req_valid4  = req_valid & ~sel;
  assign req_valid2  = req_valid & sel;
  assign req_ready_m = sel ? req_ready2 : req_ready4;
  assign rsp_valid_m = sel ? rsp_valid2 : rsp_valid4;
  assign rsp_data_m  = sel ? rsp_data2  : rsp_data4;
  assign sclk_m      = sel ? sclk2      : sclk4;
  assign cs_n_m      = sel ? cs_n2      : cs_n4;
  assign mosi_m      = sel ? mosi2      : mosi4;

  spi_pwm_host #(.HALF(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .sclk(sclk4), .cs_n(cs_n4),
    .mosi(mosi4), .miso(miso)
  );

  spi_pwm_host #(.HALF(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .sclk(sclk2), .cs_n(cs_n2),
    .mosi(mosi2), .miso(miso)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioral SPI responder ----------------
  logic [7:0]  level [2];
  logic [15:0] rx = 16'h0;
  int          rx_cnt = 0;
  logic        rd_addr = 1'b0;
  logic [15:0] last_frame = 16'h0;

  always @(posedge sclk_m) begin
    if (cs_n_m === 1'b0) begin
      rx = {rx[14:0], mosi_m};
      rx_cnt++;
      if (rx_cnt == 8) rd_addr = rx[0];
    end
  end

  always @(negedge sclk_m) begin
    if (cs_n_m === 1'b0) begin
      if (rx_cnt >= 8 && rx_cnt < 16) miso = level[rd_addr][rx_cnt-8];
      else if (rx_cnt == 16 && rx[15]) level[rx[8]] = rx[7:0];
    end
  end

  always @(posedge cs_n_m) begin
    if (rx_cnt == 16) last_frame = rx;
    rx_cnt = 0;
    rx     = 16'h0;
    miso   = 1'b0;
  end

  // ---------------- scoreboard and protocol monitors ----------------
  typedef struct {
    logic [7:0]  rsp;
    logic [15:0] frame;
    int          acc_cyc;
    int          half;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] cur_exp;
  int         cyc = 0;
  int         acc_cnt = 0;
  int         rsp_cnt = 0;
  int         run = 0;
  int         gap = 100;
  logic       prev_sclk = 1'b0;
  logic       seen_rise = 1'b0;
  logic       prev_cs = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (req_valid && req_ready_m) begin
        e.rsp     = cur_exp;
        e.frame   = {req_write, 6'b000000, req_addr, (req_write ? req_data : 8'h00)};
        e.acc_cyc = cyc;
        e.half    = sel ? 2 : 4;
        sb.push_back(e);
        acc_cnt++;
      end
      if (rsp_valid_m === 1'b1) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rsp_valid with data %0h, required none", rsp_data_m);
        end else begin
          e = sb.pop_front();
          check("rsp_data", rsp_data_m, e.rsp);
          check("latency", cyc - e.acc_cyc, 34 * e.half + 1);
          check("mosi_frame", last_frame, e.frame);
        end
      end
    end
    if (cs_n_m !== 1'b0) begin
      if (!reset) check("mosi_idle", mosi_m, 1'b0);
      run       = 0;
      prev_sclk = 1'b0;
      seen_rise = 1'b0;
      gap++;
    end else begin
      if (prev_cs) check("cs_gap_ge2", gap >= 2, 1'b1);
      gap = 0;
      check("ready_busy", req_ready_m, 1'b0);
      if (sclk_m !== prev_sclk) begin
        if (prev_sclk) check("sclk_high_len", run, sel ? 2 : 4);
        else if (seen_rise) check("sclk_low_len", run, sel ? 2 : 4);
        if (sclk_m === 1'b1) seen_rise = 1'b1;
        run = 1;
      end else begin
        run++;
      end
      prev_sclk = sclk_m;
    end
    prev_cs = (cs_n_m !== 1'b0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic w, input logic a, input logic [7:0] d);
    int n;
    bit ok;
    n         = acc_cnt;
    ok        = 1'b0;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != n) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    check("accept_in_time", ok, 1'b1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && req_ready_m === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("rsp_in_time", ok, 1'b1);
  endtask

  typedef struct {
    logic       w;
    logic       a;
    logic [7:0] d;
    logic [7:0] exp_rsp;
    logic [7:0] exp_level;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit ok;
    vecs[0] = '{w: 1'b1, a: 1'b1, d: 8'hA5, exp_rsp: 8'h00, exp_level: 8'hA5};
    vecs[1] = '{w: 1'b0, a: 1'b0, d: 8'h77, exp_rsp: 8'h3C, exp_level: 8'h3C};
    vecs[2] = '{w: 1'b0, a: 1'b1, d: 8'h00, exp_rsp: 8'hA5, exp_level: 8'hA5};
    vecs[3] = '{w: 1'b1, a: 1'b0, d: 8'h5A, exp_rsp: 8'h00, exp_level: 8'h5A};
    vecs[4] = '{w: 1'b0, a: 1'b0, d: 8'hFF, exp_rsp: 8'h5A, exp_level: 8'h5A};
    vecs[5] = '{w: 1'b1, a: 1'b1, d: 8'h96, exp_rsp: 8'h00, exp_level: 8'h96};
    vecs[6] = '{w: 1'b0, a: 1'b1, d: 8'h00, exp_rsp: 8'h96, exp_level: 8'h96};

    level[0]  = 8'h3C;
    level[1]  = 8'h00;
    miso      = 1'b0;
    sel       = 1'b0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 1'b0;
    req_data  = 8'h00;
    cur_exp   = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", cs_n4, 1'b1);
    check("rst_sclk", sclk4, 1'b0);
    check("rst_mosi", mosi4, 1'b0);
    check("rst_rsp_valid", rsp_valid4, 1'b0);
    check("rst_rsp_data", rsp_data4, 8'h00);
    check("rst_req_ready4", req_ready4, 1'b0);
    check("rst_req_ready2", req_ready2, 1'b0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", req_ready4, 1'b1);

    // Table-driven reads and writes at HALF=4.
    for (int i = 0; i < 7; i++) begin
      cur_exp = vecs[i].exp_rsp;
      send(vecs[i].w, vecs[i].a, vecs[i].d);
      wait_done();
      check("resp_level", level[vecs[i].a], vecs[i].exp_level);
    end

    // Three back-to-back writes with req_valid held high.
    n0        = rsp_cnt;
    cur_exp   = 8'h00;
    req_write = 1'b1;
    req_addr  = 1'b0;
    req_data  = 8'h11;
    req_valid = 1'b1;
    ok        = 1'b0;
    n0        = acc_cnt;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt - n0 >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    check("b2b_accepts", ok, 1'b1);
    n0 = rsp_cnt;
    wait_done();
    check("b2b_last_pulse", rsp_cnt - n0, 1);
    check("b2b_level", level[0], 8'h11);

    // req_data toggled after acceptance must not reach the wire.
    cur_exp = 8'h00;
    send(1'b1, 1'b1, 8'hC3);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      req_data = 8'($urandom);
    end
    wait_done();
    check("toggle_level", level[1], 8'hC3);

    // Reset during bit 5 of a write of 0xFF.
    n0 = rsp_cnt;
    send(1'b1, 1'b0, 8'hFF);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rx_cnt == 6) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_bit5", ok, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_cs_n", cs_n4, 1'b1);
    check("midrst_sclk", sclk4, 1'b0);
    check("midrst_ready", req_ready4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_ready_after", req_ready4, 1'b1);
    check("midrst_rsp_data", rsp_data4, 8'h00);
    repeat (200) @(posedge clk);
    #1;
    check("midrst_no_rsp", rsp_cnt - n0, 0);
    check("midrst_level", level[0], 8'h11);

    // HALF=2: write then read back.
    sel = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cur_exp = 8'h00;
    send(1'b1, 1'b0, 8'h01);
    wait_done();
    check("h2_level", level[0], 8'h01);
    cur_exp = 8'h01;
    send(1'b0, 1'b0, 8'h00);
    wait_done();

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
